serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes diff = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first, using a single full-subtractor cell.
- Inverse arithmetic companion to the structural ripple adder chain. Trades area for latency in datapaths where subtraction is infrequent.
- Operands are accepted with a start/busy/done handshake.
- Results are held stable on registered outputs until the next accepted operation.

Parameters:
- WIDTH, 4, operand and result width in bits (WIDTH >= 2)

Ports:
- clk  input  1  single system clock, rising-edge
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while an operation is in progress (SHIFT state)
- done  output  1  one-cycle pulse; diff/bout valid from this cycle onward
- diff  output  WIDTH  result a - b - bin mod 2^WIDTH
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned)

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset is asynchronous and active-low (rst_n).
- While rst_n = 0:
  - state = IDLE.
  - busy, done, bout, counter, borrow register = 0.
  - diff and internal a/b/diff shift registers = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at a rising edge loads the a, b and bin registers (bin into the borrow register), clears counter, and moves to SHIFT.
  - busy = 1 from the next cycle.
  - start = 0: remain in IDLE.
- SHIFT: each edge processes bit i = counter:
  - d = a[i] ^ b[i] ^ br
  - br_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br)
  - d shifts into the internal diff register from the MSB end; the a and b registers shift right.
  - Counter increments.
  - When counter reaches WIDTH-1 at an edge, that edge processes the last bit and transitions to DONE. On the same edge, the diff output register loads the final shift-register value and bout loads br_next.
  - busy is high for exactly WIDTH cycles.
- DONE:
  - done = 1, busy = 0, for exactly one cycle.
  - Unconditionally returns to IDLE.
- Latency:
  - start sampled at edge k → done high in the cycle following edge k+WIDTH.
  - Throughput is at most one operation per WIDTH+2 cycles.
- start handling:
  - Ignored while in SHIFT or DONE; operand registers are not disturbed.
  - Changes on a/b/bin after acceptance have no effect on the operation in progress.
- Output stability:
  - diff and bout change only on the SHIFT→DONE edge or on reset.
  - They hold their values through IDLE and through the next operation until its own SHIFT→DONE edge.
  - Partial results are never visible on diff.
- Reset mid-operation: all state returns immediately to reset values. No done pulse; the operation is abandoned.
- Arithmetic:
  - All operands are unsigned.
  - bout is the borrow out of bit WIDTH-1.
  - {bout, diff} equals (a - b - bin) in (WIDTH+1)-bit two's complement.
- Counter width: $clog2(WIDTH).

Decomposition:
- Shared package sub_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - function for counter width
- Sub-module full_sub_bit:
  - Purely combinational.
  - Ports: output d, bo; inputs x, y, bi.
  - Instantiated once inside serial_subtractor.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- WIDTH=4, a=9, b=5, bin=0, start one cycle → busy high 4 cycles, done pulse at cycle 5 after the start edge, diff=4, bout=0.
- WIDTH=4, a=5, b=9, bin=0 → diff=12 (4'b1100), bout=1.
- WIDTH=4, a=0, b=0, bin=1 → diff=15, bout=1. Follow with a=15, b=15, bin=0 → diff=0, bout=0, and the previous result stays held until that done.
- Ignored start:
  - Start a=7, b=2.
  - Pulse start with a=1, b=1 during cycle 2 of SHIFT, and again in the DONE cycle.
  - Expected: exactly one done, diff=5. No second operation begins until start is seen in IDLE.
- Reset mid-operation:
  - Start a=12, b=3; drop rst_n asynchronously (between edges) in cycle 2.
  - Expected: busy/done/diff/bout = 0 immediately, no done pulse.
  - After release, a new op a=6, b=6 → diff=0, bout=0.
- WIDTH=8: a=255, b=1 → diff=254, bout=0; then a=0, b=1 → diff=255, bout=1. busy high 8 cycles each.

Source files
------------

// File: rtl/sub_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - sub_state_t : FSM state encoding (IDLE, SHIFT, DONE)
//   - cnt_width() : width of the bit-position counter for a given operand width
// -----------------------------------------------------------------------------
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // Counter must hold values 0 .. w-1.
    // The result is clamped to at least 1 so that the counter is never zero-width.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_sub_bit.sv
// -----------------------------------------------------------------------------
// full_sub_bit
// One-bit full subtractor cell, purely combinational: computes x - y - bi.
// Ports:
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
// -----------------------------------------------------------------------------
module full_sub_bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    // A borrow is needed when y > x, or when x == y and a borrow arrives.
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// using a single full_sub_bit cell.
//
// Handshake: start is only looked at in IDLE. On an accepted start, the
// operands are captured and busy rises on the next cycle for exactly WIDTH
// cycles. done then pulses for one cycle. diff/bout are registered and only
// update on the SHIFT->DONE edge, so they hold the previous result during a
// new operation and never show partial values.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : operation request (sampled in IDLE only)
//   a, b  : minuend / subtrahend, captured on accepted start
//   bin   : borrow in, captured on accepted start
//   busy  : high while in SHIFT
//   done  : one-cycle pulse when the result becomes valid
//   diff  : a - b - bin mod 2^WIDTH
//   bout  : borrow out of bit WIDTH-1 (1 iff a < b + bin)
// -----------------------------------------------------------------------------
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state, state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] d_sr_next;

    // The operand registers shift right, so bit i of the original operand is
    // always at position 0 when counter == i.
    full_sub_bit u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // New difference bit enters from the MSB end; after WIDTH shifts the LSB
    // result has walked down to bit 0.
    assign d_sr_next = {cell_d, d_sr[WIDTH-1:1]};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state / decoded outputs ----------------
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    d_sr <= d_sr_next;
                    br   <= cell_bo;
                    cnt  <= cnt + CW'(1);
                    // Last bit: publish the complete result on the same edge.
                    if (cnt == LAST) begin
                        diff <= d_sr_next;
                        bout <= cell_bo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed bench for serial_subtractor with a WIDTH=4 and a WIDTH=8 instance.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_subtractor;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT signals ----------------
    logic       start4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    // ---------------- driver ----------------
    // Drives one start, then observes WIDTH+6 cycles. Cycle 1 is the first
    // cycle after the accepting edge. Optional extra start pulses (a=1,b=1)
    // are driven during cycles pa and pb (0 = none).
    task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          input logic bi, input int pa, input int pb,
                          output logic [7:0] d, output logic bo,
                          output int busy_cnt, output int done_cyc, output int done_cnt,
                          output logic [7:0] pre_d, output bit held);
        logic       bs, ds, bos;
        logic [7:0] dfs;
        logic       st;
        d = '0; bo = 1'b0; busy_cnt = 0; done_cyc = 0; done_cnt = 0;
        pre_d = '0; held = 1'b1;
        @(negedge clk);
        if (w == 4) begin
            start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi;
        end else begin
            start8 = 1'b1; a8 = av; b8 = bv; bin8 = bi;
        end
        for (int cyc = 1; cyc <= w + 6; cyc++) begin
            @(negedge clk);
            if (w == 4) begin
                bs = busy4; ds = done4; dfs = {4'b0, diff4}; bos = bout4;
            end else begin
                bs = busy8; ds = done8; dfs = diff8; bos = bout8;
            end
            if (cyc == 1) pre_d = dfs;
            if (bs) busy_cnt++;
            if (ds) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    d = dfs;
                    bo = bos;
                end
            end
            if (done_cnt == 0 && dfs !== pre_d) held = 1'b0;
            st = (cyc == pa) || (cyc == pb);
            if (w == 4) begin
                start4 = st;
                if (st) begin a4 = 4'd1; b4 = 4'd1; bin4 = 1'b0; end
            end else begin
                start8 = st;
                if (st) begin a8 = 8'd1; b8 = 8'd1; bin8 = 1'b0; end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy4, done4, diff4, bout4} !== 7'b0) begin
            errors++;
            $display("FAIL reset4: busy=%b done=%b diff=%0d bout=%b, required all 0",
                     busy4, done4, diff4, bout4);
        end
        checks++;
        if ({busy8, done8, diff8, bout8} !== 11'b0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b diff=%0d bout=%b, required all 0",
                     busy8, done8, diff8, bout8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input string nm, input int w, input logic [7:0] av,
                              input logic [7:0] bv, input logic bi,
                              input logic [7:0] exp_d, input logic exp_bo,
                              input logic [7:0] exp_pre);
        logic [7:0] d, pre;
        logic       bo;
        int         bc, dc, dn;
        bit         held;
        run_op(w, av, bv, bi, 0, 0, d, bo, bc, dc, dn, pre, held);
        checks++;
        if (d !== exp_d || bo !== exp_bo) begin
            errors++;
            $display("FAIL %s result: diff=%0d bout=%b, required diff=%0d bout=%b",
                     nm, d, bo, exp_d, exp_bo);
        end
        checks++;
        if (bc != w || dc != w + 1 || dn != 1) begin
            errors++;
            $display("FAIL %s timing: busy_cycles=%0d done_cycle=%0d done_count=%0d, required %0d %0d 1",
                     nm, bc, dc, dn, w, w + 1);
        end
        checks++;
        if (pre !== exp_pre || !held) begin
            errors++;
            $display("FAIL %s hold: prev diff=%0d held=%0d, required prev diff=%0d held=1",
                     nm, pre, held, exp_pre);
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] d, pre;
        logic       bo;
        int         bc, dc, dn;
        bit         held;
        // Extra pulses in SHIFT cycle 2 and in the DONE cycle (cycle 5).
        run_op(4, 8'd7, 8'd2, 1'b0, 2, 5, d, bo, bc, dc, dn, pre, held);
        checks++;
        if (d !== 8'd5 || bo !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start result: diff=%0d bout=%b, required diff=5 bout=0", d, bo);
        end
        checks++;
        if (dn != 1 || bc != 4) begin
            errors++;
            $display("FAIL ignored_start count: done_count=%0d busy_cycles=%0d, required 1 and 4", dn, bc);
        end
        checks++;
        if (diff4 !== 4'd5 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start after: diff=%0d busy=%b, required diff=5 busy=0", diff4, busy4);
        end
    endtask

    task automatic test_reset_mid_op();
        int dn;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd12; b4 = 4'd3; bin4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy4, done4, diff4, bout4} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b diff=%0d bout=%b, required all 0",
                     busy4, done4, diff4, bout4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4 || busy4) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL reset_mid_op no_done: active cycles=%0d, required 0", dn);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_basic("w4_9m5",   4, 8'd9,   8'd5, 1'b0, 8'd4,   1'b0, 8'd0);
        test_basic("w4_5m9",   4, 8'd5,   8'd9, 1'b0, 8'd12,  1'b1, 8'd4);
        test_basic("w4_0m0b",  4, 8'd0,   8'd0, 1'b1, 8'd15,  1'b1, 8'd12);
        test_basic("w4_15m15", 4, 8'd15,  8'd15, 1'b0, 8'd0,  1'b0, 8'd15);
        test_ignored_start();
        test_reset_mid_op();
        test_basic("w4_6m6",   4, 8'd6,   8'd6, 1'b0, 8'd0,   1'b0, 8'd0);
        test_basic("w8_255m1", 8, 8'd255, 8'd1, 1'b0, 8'd254, 1'b0, 8'd0);
        test_basic("w8_0m1",   8, 8'd0,   8'd1, 1'b0, 8'd255, 1'b1, 8'd254);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
